// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 5-stage MIPS pipeline.
//   - Merges IF/ID/EX/MEM stall requests into a per-stage stall vector (combinational).
//   - Arbitrates PC redirects (branch, pending branch, exception, ERET) into one
//     registered load/target pair.
//   - Runs a bus-wait watchdog that turns runaway memory stalls into an exception.
// Ports:
//   clk, rst (async, active-low)
//   stallreq_if/id/ex/mem   stall requests from each stage
//   branch_flag_i/target_i  taken branch from ID
//   except_valid_i, eret_i, epc_i  MEM-stage exception/ERET commit and CP0 EPC
//   stall_o[5:0] ([0]=PC .. [5]=WB), bbl_o (= stall_o[0])
//   flush_o, pc_load_o, pc_target_o, timeout_o  registered control outputs
//   state_o  RUN=0, STALL=1, FLUSH=2
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h00000020,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        except_valid_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  output logic [5:0]  stall_o,
  output logic        bbl_o,
  output logic        flush_o,
  output logic        pc_load_o,
  output logic [31:0] pc_target_o,
  output logic        timeout_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {StRun = 2'd0, StStall = 2'd1, StFlush = 2'd2} state_e;

  localparam logic [2:0] FcntInit = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WdLast   = 8'(TIMEOUT - 1);

  state_e      r_state, w_state_next;
  logic [2:0]  r_fcnt, w_fcnt_next;
  logic [7:0]  r_wd_cnt, w_wd_cnt_next;
  logic        r_pend, w_pend_next;
  logic [31:0] r_pend_tgt, w_pend_tgt_next;
  logic        r_flush, w_flush_next;
  logic        r_pc_load, w_pc_load_next;
  logic [31:0] r_pc_target, w_pc_target_next;
  logic        r_timeout, w_timeout_next;

  logic        w_in_flush, w_any_req, w_bus_wait, w_wd_fire, w_exc;
  logic [5:0]  w_stall;

  assign w_in_flush = (r_state == StFlush);
  assign w_any_req  = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;
  assign w_bus_wait = stallreq_if | stallreq_mem;
  // Fires on the edge where the count would reach TIMEOUT.
  assign w_wd_fire  = !w_in_flush && w_bus_wait && (r_wd_cnt == WdLast);
  assign w_exc      = !w_in_flush && (except_valid_i || w_wd_fire);

  always_comb begin
    w_stall = 6'b000000;
    if (!w_in_flush) begin
      if (stallreq_mem)     w_stall = 6'b011111;
      else if (stallreq_ex) w_stall = 6'b001111;
      else if (stallreq_id) w_stall = 6'b000111;
      else if (stallreq_if) w_stall = 6'b000011;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_fcnt_next      = r_fcnt;
    w_pend_next      = r_pend;
    w_pend_tgt_next  = r_pend_tgt;
    w_pc_load_next   = 1'b0;
    w_pc_target_next = r_pc_target;
    w_timeout_next   = 1'b0;
    w_wd_cnt_next    = r_wd_cnt;

    unique case (r_state)
      StRun, StStall: begin
        if (w_exc) begin
          w_state_next = StFlush;
          w_fcnt_next  = FcntInit;
        end else if (w_any_req) begin
          w_state_next = StStall;
        end else begin
          w_state_next = StRun;
        end
      end
      StFlush: begin
        if (r_fcnt == 3'd0) w_state_next = StRun;
        else                w_fcnt_next  = r_fcnt - 3'd1;
      end
      default: w_state_next = StRun;
    endcase

    // Exception wins over any branch; branches arriving during FLUSH are flushed junk.
    if (w_exc) begin
      w_pc_load_next   = 1'b1;
      w_pc_target_next = (except_valid_i && eret_i) ? epc_i : EXC_VECTOR;
      w_pend_next      = 1'b0;
      w_timeout_next   = w_wd_fire;
    end else if (!w_in_flush) begin
      if (branch_flag_i) begin
        if (w_stall[0]) begin
          w_pend_next     = 1'b1;
          w_pend_tgt_next = branch_target_i;
        end else begin
          w_pc_load_next   = 1'b1;
          w_pc_target_next = branch_target_i;
          w_pend_next      = 1'b0;
        end
      end else if (r_pend && !w_stall[0]) begin
        w_pc_load_next   = 1'b1;
        w_pc_target_next = r_pend_tgt;
        w_pend_next      = 1'b0;
      end
    end

    if (w_exc || w_in_flush || !w_bus_wait) w_wd_cnt_next = 8'd0;
    else if (r_wd_cnt != 8'hFF)             w_wd_cnt_next = r_wd_cnt + 8'd1;

    w_flush_next = (w_state_next == StFlush);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StRun;
      r_fcnt      <= 3'd0;
      r_wd_cnt    <= 8'd0;
      r_pend      <= 1'b0;
      r_pend_tgt  <= 32'd0;
      r_flush     <= 1'b0;
      r_pc_load   <= 1'b0;
      r_pc_target <= 32'd0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_fcnt      <= w_fcnt_next;
      r_wd_cnt    <= w_wd_cnt_next;
      r_pend      <= w_pend_next;
      r_pend_tgt  <= w_pend_tgt_next;
      r_flush     <= w_flush_next;
      r_pc_load   <= w_pc_load_next;
      r_pc_target <= w_pc_target_next;
      r_timeout   <= w_timeout_next;
    end
  end

  assign stall_o     = w_stall;
  assign bbl_o       = w_stall[0];
  assign flush_o     = r_flush;
  assign pc_load_o   = r_pc_load;
  assign pc_target_o = r_pc_target;
  assign timeout_o   = r_timeout;
  assign state_o     = r_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl (FLUSH_CYCLES=2, TIMEOUT=4). Expected redirect targets are
// pushed to a queue when the stimulus is driven; a monitor pops one per pc_load_o.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        except_valid_i, eret_i;
  logic [31:0] epc_i;
  logic [5:0]  stall_o;
  logic        bbl_o, flush_o, pc_load_o, timeout_o;
  logic [31:0] pc_target_o;
  logic [1:0]  state_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb_q[$];
  logic [31:0] sb_exp;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .EXC_VECTOR  (32'h00000020),
    .FLUSH_CYCLES(2),
    .TIMEOUT     (4)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_if    (stallreq_if),
    .stallreq_id    (stallreq_id),
    .stallreq_ex    (stallreq_ex),
    .stallreq_mem   (stallreq_mem),
    .branch_flag_i  (branch_flag_i),
    .branch_target_i(branch_target_i),
    .except_valid_i (except_valid_i),
    .eret_i         (eret_i),
    .epc_i          (epc_i),
    .stall_o        (stall_o),
    .bbl_o          (bbl_o),
    .flush_o        (flush_o),
    .pc_load_o      (pc_load_o),
    .pc_target_o    (pc_target_o),
    .timeout_o      (timeout_o),
    .state_o        (state_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // req = {mem, ex, id, if}
  task automatic drive(input logic [3:0] req, input logic br, input logic [31:0] bt,
                       input logic ex, input logic er, input logic [31:0] epc);
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
    branch_flag_i   = br;
    branch_target_i = bt;
    except_valid_i  = ex;
    eret_i          = er;
    epc_i           = epc;
  endtask

  task automatic idle();
    drive(4'b0000, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  // Every observed redirect must match the oldest expected target.
  always @(negedge clk) begin
    #2;
    if (pc_load_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("pc_load_unexpected", 32'd1, 32'd0);
      end else begin
        sb_exp = sb_q.pop_front();
        chk("sb_target", pc_target_o, sb_exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b0;
    idle();
    #3;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_flush", 32'(flush_o), 32'd0);
    chk("rst_pc_load", 32'(pc_load_o), 32'd0);
    chk("rst_target", pc_target_o, 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // EX stall for 3 cycles
    for (int i = 0; i < 3; i++) begin
      drive(4'b0100, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      #1;
      chk("ex_stall", 32'(stall_o), 32'h0F);
      chk("ex_bbl", 32'(bbl_o), 32'd1);
      if (i > 0) chk("ex_state", 32'(state_o), 32'd1);
      @(negedge clk);
    end
    idle();
    #1;
    chk("ex_rel_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    #1;
    chk("ex_rel_state", 32'(state_o), 32'd0);
    @(negedge clk);

    // Priority: mem over id, then id alone, then if alone
    drive(4'b1010, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    #1;
    chk("prio_mem_id", 32'(stall_o), 32'h1F);
    @(negedge clk);
    drive(4'b0010, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    #1;
    chk("prio_id", 32'(stall_o), 32'h07);
    @(negedge clk);
    drive(4'b0001, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    #1;
    chk("prio_if", 32'(stall_o), 32'h03);
    @(negedge clk);
    idle();
    @(negedge clk);

    // Unstalled branch: one-cycle redirect
    drive(4'b0000, 1'b1, 32'h00400100, 1'b0, 1'b0, 32'd0);
    sb_q.push_back(32'h00400100);
    @(negedge clk);
    idle();
    #1;
    chk("br_load", 32'(pc_load_o), 32'd1);
    chk("br_target", pc_target_o, 32'h00400100);
    @(negedge clk);
    #1;
    chk("br_pulse_end", 32'(pc_load_o), 32'd0);
    @(negedge clk);

    // Branch under a 3-cycle mem stall: pending until release
    drive(4'b1000, 1'b1, 32'h00400200, 1'b0, 1'b0, 32'd0);
    sb_q.push_back(32'h00400200);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      drive(4'b1000, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      #1;
      chk("pend_mem_hold", 32'(pc_load_o), 32'd0);
      @(negedge clk);
    end
    idle();
    #1;
    chk("pend_mem_rel0", 32'(pc_load_o), 32'd0);
    @(negedge clk);
    #1;
    chk("pend_mem_load", 32'(pc_load_o), 32'd1);
    chk("pend_mem_target", pc_target_o, 32'h00400200);
    @(negedge clk);

    // Two branches under a 4-cycle EX stall: the later one wins
    drive(4'b0100, 1'b1, 32'h00400300, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    drive(4'b0100, 1'b1, 32'h00400400, 1'b0, 1'b0, 32'd0);
    sb_q.push_back(32'h00400400);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      drive(4'b0100, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      #1;
      chk("pend_ex_hold", 32'(pc_load_o), 32'd0);
      @(negedge clk);
    end
    idle();
    @(negedge clk);
    #1;
    chk("pend_ex_load", 32'(pc_load_o), 32'd1);
    chk("pend_ex_target", pc_target_o, 32'h00400400);
    @(negedge clk);

    // ERET with a simultaneous branch and an ID stall held into FLUSH
    drive(4'b0010, 1'b1, 32'h00400500, 1'b1, 1'b1, 32'hBFC00180);
    sb_q.push_back(32'hBFC00180);
    @(negedge clk);
    drive(4'b0010, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    #1;
    chk("eret_flush1", 32'(flush_o), 32'd1);
    chk("eret_load", 32'(pc_load_o), 32'd1);
    chk("eret_target", pc_target_o, 32'hBFC00180);
    chk("eret_stall1", 32'(stall_o), 32'd0);
    chk("eret_state", 32'(state_o), 32'd2);
    @(negedge clk);
    drive(4'b0010, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);  // exception ignored in FLUSH
    #1;
    chk("eret_flush2", 32'(flush_o), 32'd1);
    chk("eret_load_once", 32'(pc_load_o), 32'd0);
    chk("eret_stall2", 32'(stall_o), 32'd0);
    @(negedge clk);
    idle();
    #1;
    chk("eret_flush_end", 32'(flush_o), 32'd0);
    chk("eret_state_run", 32'(state_o), 32'd0);
    chk("eret_no_reload", 32'(pc_load_o), 32'd0);
    @(negedge clk);
    @(negedge clk);

    // Watchdog: mem held 4 cycles -> timeout exception
    for (int i = 0; i < 4; i++) begin
      drive(4'b1000, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      #1;
      chk("wd_quiet", 32'(timeout_o), 32'd0);
      @(negedge clk);
    end
    sb_q.push_back(32'h00000020);
    idle();
    #1;
    chk("wd_timeout", 32'(timeout_o), 32'd1);
    chk("wd_load", 32'(pc_load_o), 32'd1);
    chk("wd_target", pc_target_o, 32'h00000020);
    chk("wd_flush", 32'(flush_o), 32'd1);
    @(negedge clk);
    #1;
    chk("wd_pulse_end", 32'(timeout_o), 32'd0);
    chk("wd_flush2", 32'(flush_o), 32'd1);
    #2;
    rst = 1'b0;  // async reset mid-FLUSH
    #1;
    chk("arst_flush", 32'(flush_o), 32'd0);
    chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_target", pc_target_o, 32'd0);
    chk("arst_load", 32'(pc_load_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("arst_no_redirect", 32'(pc_load_o), 32'd0);
      chk("arst_no_flush", 32'(flush_o), 32'd0);
      @(negedge clk);
    end

    // Watchdog fire together with an ERET commit: single FLUSH, EPC target
    for (int i = 0; i < 3; i++) begin
      drive(4'b1000, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      @(negedge clk);
    end
    drive(4'b1000, 1'b0, 32'd0, 1'b1, 1'b1, 32'h80001000);
    sb_q.push_back(32'h80001000);
    @(negedge clk);
    idle();
    #1;
    chk("both_timeout", 32'(timeout_o), 32'd1);
    chk("both_target", pc_target_o, 32'h80001000);
    chk("both_flush", 32'(flush_o), 32'd1);
    @(negedge clk);
    #1;
    chk("both_one_pulse", 32'(timeout_o), 32'd0);
    @(negedge clk);
    #1;
    chk("both_flush_end", 32'(flush_o), 32'd0);
    @(negedge clk);
    @(negedge clk);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
